// File: rtl/pea_result_drain_if.sv
// Host-side half-word stream of the PEA result drain.
// Valid/ready handshake with a frame-end marker.
interface pea_result_drain_if #(
    parameter int WIDTH_OUT = 16
);
    logic [WIDTH_OUT-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/pea_result_drain.sv
// PEA result drain: pops result/status pairs and
// streams each pair to the host as four half-words.
module pea_result_drain #(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_OUT = 16,
    parameter int POP_W     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                drain_en,
    input  logic                clr_stats,
    input  logic [POP_W-1:0]    result_pop,
    input  logic [POP_W-1:0]    status_pop,
    input  logic [WIDTH_IN-1:0] result_data,
    input  logic [WIDTH_IN-1:0] status_data,
    output logic                rd_en_result,
    output logic                rd_en_status,
    output logic                busy,
    output logic [15:0]         pairs_sent,
    output logic                err_seen,
    pea_result_drain_if.master  host
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        S0,
        S1,
        S2,
        S3
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH_IN-1:0] res_q, res_d;
    logic [WIDTH_IN-1:0] sts_q, sts_d;
    logic [15:0]         pairs_q, pairs_d;
    logic                err_q, err_d;
    logic                rd_en_q, rd_en_d;

    logic                 valid_c;
    logic                 last_c;
    logic [WIDTH_OUT-1:0] data_c;

    // Next-state, datapath capture and stream output decode
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        sts_d   = sts_q;
        pairs_d = pairs_q;
        err_d   = err_q;
        rd_en_d = 1'b0;
        valid_c = 1'b0;
        last_c  = 1'b0;
        data_c  = '0;
        unique case (state_q)
            IDLE: begin
                if (drain_en && (result_pop != '0)
                    && (status_pop != '0)) begin
                    state_d = FETCH;
                    rd_en_d = 1'b1;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                res_d   = result_data;
                sts_d   = status_data;
                state_d = S0;
                if (status_data != '0) begin
                    err_d = 1'b1;
                end
            end
            S0: begin
                valid_c = 1'b1;
                data_c  = res_q[WIDTH_IN-1:WIDTH_OUT];
                if (host.out_ready) begin
                    state_d = S1;
                end
            end
            S1: begin
                valid_c = 1'b1;
                data_c  = res_q[WIDTH_OUT-1:0];
                if (host.out_ready) begin
                    state_d = S2;
                end
            end
            S2: begin
                valid_c = 1'b1;
                data_c  = sts_q[WIDTH_IN-1:WIDTH_OUT];
                if (host.out_ready) begin
                    state_d = S3;
                end
            end
            S3: begin
                valid_c = 1'b1;
                last_c  = 1'b1;
                data_c  = sts_q[WIDTH_OUT-1:0];
                if (host.out_ready) begin
                    state_d = IDLE;
                    pairs_d = pairs_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Host clear overrides a same-cycle count or error set
        if (clr_stats) begin
            pairs_d = '0;
            err_d   = 1'b0;
        end
    end

    // State, latched pair, statistics and pop strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            res_q   <= '0;
            sts_q   <= '0;
            pairs_q <= '0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            sts_q   <= sts_d;
            pairs_q <= pairs_d;
            err_q   <= err_d;
            rd_en_q <= rd_en_d;
        end
    end

    assign rd_en_result   = rd_en_q;
    assign rd_en_status   = rd_en_q;
    assign busy           = (state_q != IDLE);
    assign pairs_sent     = pairs_q;
    assign err_seen       = err_q;
    assign host.out_valid = valid_c;
    assign host.out_last  = last_c;
    assign host.out_data  = data_c;

endmodule

// File: tb/tb_pea_result_drain.sv
// Directed bench for pea_result_drain with FIFO models
// and a host-side beat recorder.
module tb_pea_result_drain;

    localparam int WI = 32;
    localparam int WO = 16;
    localparam int PW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          drain_en;
    logic          clr_stats;
    logic [PW-1:0] result_pop;
    logic [PW-1:0] status_pop;
    logic [WI-1:0] result_data = '0;
    logic [WI-1:0] status_data = '0;
    logic          rd_en_result;
    logic          rd_en_status;
    logic          busy;
    logic [15:0]   pairs_sent;
    logic          err_seen;

    pea_result_drain_if #(.WIDTH_OUT(WO)) host_if ();

    pea_result_drain #(
        .WIDTH_IN (WI),
        .WIDTH_OUT(WO),
        .POP_W    (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .drain_en    (drain_en),
        .clr_stats   (clr_stats),
        .result_pop  (result_pop),
        .status_pop  (status_pop),
        .result_data (result_data),
        .status_data (status_data),
        .rd_en_result(rd_en_result),
        .rd_en_status(rd_en_status),
        .busy        (busy),
        .pairs_sent  (pairs_sent),
        .err_seen    (err_seen),
        .host        (host_if.master)
    );

    always #5 clk = ~clk;

    // FIFO models: bench owns write pointers, model owns read pointers
    logic [31:0] rmem [256];
    logic [31:0] smem [256];
    logic [7:0]  rwp = '0;
    logic [7:0]  swp = '0;
    logic [7:0]  rrp = '0;
    logic [7:0]  srp = '0;
    logic [7:0]  rdiff;
    logic [7:0]  sdiff;

    assign rdiff      = rwp - rrp;
    assign sdiff      = swp - srp;
    assign result_pop = rdiff[PW-1:0];
    assign status_pop = sdiff[PW-1:0];

    always @(posedge clk) begin
        if (rd_en_result) begin
            result_data <= rmem[rrp];
            rrp         <= rrp + 8'd1;
        end
        if (rd_en_status) begin
            status_data <= smem[srp];
            srp         <= srp + 8'd1;
        end
    end

    // Beat recorder and pop counters, sampled mid-cycle
    logic [16:0] beats [1024];
    int          beat_n = 0;
    int          rd_r   = 0;
    int          rd_s   = 0;
    int          dbl    = 0;
    logic        prev_r = 1'b0;

    always @(negedge clk) begin
        if (host_if.out_valid && host_if.out_ready) begin
            beats[beat_n] <= {host_if.out_last, host_if.out_data};
            beat_n        <= beat_n + 1;
        end
        if (rd_en_result) rd_r <= rd_r + 1;
        if (rd_en_status) rd_s <= rd_s + 1;
        if (rd_en_result && prev_r) dbl <= dbl + 1;
        prev_r <= rd_en_result;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_r(input logic [31:0] r);
        rmem[rwp] = r;
        rwp       = rwp + 8'd1;
    endtask

    task automatic push_s(input logic [31:0] s);
        smem[swp] = s;
        swp       = swp + 8'd1;
    endtask

    task automatic push(input logic [31:0] r, input logic [31:0] s);
        push_r(r);
        push_s(s);
    endtask

    task automatic wait_beats(input string tag, input int target);
        for (int i = 0; i < 300 && beat_n < target; i++) tick();
        chk(tag, beat_n, target);
    endtask

    task automatic chk_frame(input string tag, input int b,
                             input logic [31:0] r,
                             input logic [31:0] s);
        logic [31:0] e0, e1, e2, e3;
        e0 = {16'h0000, r[31:16]};
        e1 = {16'h0000, r[15:0]};
        e2 = {16'h0000, s[31:16]};
        e3 = {15'h0000, 1'b1, s[15:0]};
        chk({tag, "_b0"}, {15'h0, beats[b]},   e0);
        chk({tag, "_b1"}, {15'h0, beats[b+1]}, e1);
        chk({tag, "_b2"}, {15'h0, beats[b+2]}, e2);
        chk({tag, "_b3"}, {15'h0, beats[b+3]}, e3);
    endtask

    int base;
    int r0;
    int bsy;

    initial begin
        rst       = 1'b0;
        drain_en  = 1'b1;
        clr_stats = 1'b0;
        host_if.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_busy",  busy, 0);
        chk("rst_valid", host_if.out_valid, 0);
        chk("rst_data",  host_if.out_data, 0);
        chk("rst_last",  host_if.out_last, 0);
        chk("rst_rden",  rd_en_result, 0);
        chk("rst_pairs", pairs_sent, 0);
        chk("rst_err",   err_seen, 0);
        rst = 1'b1;
        tick();

        // single pair, latency T+3
        base = beat_n;
        push(32'h12345678, 32'h0);
        tick();
        chk("t1_rd_r", rd_en_result, 1);
        chk("t1_rd_s", rd_en_status, 1);
        chk("t1_v0",   host_if.out_valid, 0);
        tick();
        chk("t1_rd_off", rd_en_result, 0);
        chk("t1_busy",   busy, 1);
        chk("t1_v1",     host_if.out_valid, 0);
        tick();
        chk("t1_v2",  host_if.out_valid, 1);
        chk("t1_d2",  host_if.out_data, 32'h1234);
        wait_beats("t1_beats", base + 4);
        chk_frame("t1", base, 32'h12345678, 32'h0);
        tick();
        chk("t1_pairs", pairs_sent, 1);
        chk("t1_err",   err_seen, 0);
        chk("t1_idle",  busy, 0);
        chk("t1_npop_r", rd_r, 1);
        chk("t1_npop_s", rd_s, 1);

        // backpressure in S1
        base = beat_n;
        push(32'h9ABC5678, 32'h0);
        repeat (4) tick();
        host_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_v", host_if.out_valid, 1);
            chk("t2_hold_d", host_if.out_data, 32'h5678);
            tick();
        end
        chk("t2_npop", rd_r, 2);
        host_if.out_ready = 1'b1;
        wait_beats("t2_beats", base + 4);
        chk_frame("t2", base, 32'h9ABC5678, 32'h0);
        tick();
        chk("t2_pairs", pairs_sent, 2);

        // error status is sticky until cleared
        base = beat_n;
        push(32'h00000001, 32'h00000003);
        repeat (2) tick();
        chk("t3_err_pre", err_seen, 0);
        tick();
        chk("t3_err_set", err_seen, 1);
        wait_beats("t3_beats", base + 4);
        chk_frame("t3", base, 32'h00000001, 32'h00000003);
        base = beat_n;
        push(32'h00000002, 32'h0);
        wait_beats("t3_beats2", base + 4);
        tick();
        chk("t3_err_stk", err_seen, 1);
        chk("t3_pairs",   pairs_sent, 4);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("t3_clr_err",   err_seen, 0);
        chk("t3_clr_pairs", pairs_sent, 0);

        // unbalanced FIFOs never pop
        base = beat_n;
        r0   = rd_r;
        bsy  = 0;
        push_r(32'h11112222);
        push_r(32'h33334444);
        repeat (20) begin
            tick();
            if (busy) bsy++;
        end
        chk("t4_nopop", rd_r, r0);
        chk("t4_busy",  bsy, 0);
        push_s(32'h0);
        push_s(32'h0);
        wait_beats("t4_beats", base + 8);
        chk_frame("t4a", base, 32'h11112222, 32'h0);
        chk_frame("t4b", base + 4, 32'h33334444, 32'h0);
        tick();
        chk("t4_pairs", pairs_sent, 2);
        chk("t4_pops",  rd_r, r0 + 2);
        chk("t4_dbl",   dbl, 0);

        // async reset while in S2
        push(32'hAAAABBBB, 32'h0000CCCC);
        repeat (5) tick();
        chk("t5_s2_v", host_if.out_valid, 1);
        chk("t5_s2_d", host_if.out_data, 32'h0000);
        chk("t5_s2_e", err_seen, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_rv", host_if.out_valid, 0);
        chk("t5_rd", host_if.out_data, 0);
        chk("t5_rb", busy, 0);
        chk("t5_rp", pairs_sent, 0);
        chk("t5_re", err_seen, 0);
        chk("t5_rl", host_if.out_last, 0);
        #1 rst = 1'b1;
        tick();
        chk("t5_idle", busy, 0);
        base = beat_n;
        push(32'h0F0F1E1E, 32'h00000007);
        wait_beats("t5_beats", base + 4);
        chk_frame("t5", base, 32'h0F0F1E1E, 32'h00000007);
        tick();
        chk("t5_pairs", pairs_sent, 1);

        // wrap and drain_en gating
        force dut.pairs_q = 16'hFFFF;
        tick();
        release dut.pairs_q;
        tick();
        chk("t6_pre", pairs_sent, 32'hFFFF);
        drain_en = 1'b0;
        r0 = rd_r;
        base = beat_n;
        push(32'h5555AAAA, 32'h0);
        repeat (10) tick();
        chk("t6_gate_pop",  rd_r, r0);
        chk("t6_gate_busy", busy, 0);
        drain_en = 1'b1;
        repeat (2) tick();
        drain_en = 1'b0;
        wait_beats("t6_beats", base + 4);
        chk_frame("t6", base, 32'h5555AAAA, 32'h0);
        tick();
        chk("t6_wrap", pairs_sent, 0);
        chk("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pea_result_drain.md
Name: pea_result_drain

Overview:
- Output-side stage of the Polynomial Evaluation Accelerator; consumes what the PEA core produces.
- Pops one 32-bit word from the result FIFO and one from the status FIFO as a pair.
- Serialises each pair as four 16-bit half-words onto a host stream with a valid/ready handshake.
- Keeps a pair counter and a sticky error flag for host polling.

Parameters:
- WIDTH_IN, 32, width of result/status FIFO words
- WIDTH_OUT, 16, width of host output stream (WIDTH_IN = 2*WIDTH_OUT)
- POP_W, 5, width of FIFO population inputs (log2 of output FIFO depth 32)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- drain_en  input  1  permits starting a new pair fetch
- clr_stats  input  1  synchronous clear of pairs_sent and err_seen
- result_pop  input  POP_W  population of result FIFO
- status_pop  input  POP_W  population of status FIFO
- result_data  input  WIDTH_IN  result FIFO read data
- status_data  input  WIDTH_IN  status FIFO read data
- rd_en_result  output  1  result FIFO pop strobe
- rd_en_status  output  1  status FIFO pop strobe
- out_data  output  WIDTH_OUT  host stream data
- out_valid  output  1  host stream valid
- out_ready  input  1  host stream ready
- out_last  output  1  marks 4th half-word of a frame
- busy  output  1  high in any state other than IDLE
- pairs_sent  output  16  completed frames, wraps 0xFFFF->0
- err_seen  output  1  sticky: some latched status word was non-zero

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; latched result/status registers 0. A pair already popped when reset hits is discarded.
- FIFO read timing (decided): FIFO data_out updates at the clock edge sampling rd_en=1; valid from the following cycle.
- FSM states: IDLE, FETCH, LATCH, S0, S1, S2, S3.
- IDLE -> FETCH when drain_en=1, result_pop!=0 and status_pop!=0. Otherwise stay in IDLE.
- If only one FIFO is non-empty, stay in IDLE. Never pop unpaired.
- FETCH: rd_en_result=rd_en_status=1 for exactly this one cycle, registered outputs. Next state is LATCH.
- LATCH: capture result_data/status_data into internal registers. If status_data!=0, set err_seen. Next state is S0.
- S0..S3: out_valid=1. out_data is, in order:
  - S0: result[31:16]
  - S1: result[15:0]
  - S2: status[31:16]
  - S3: status[15:0]
- Advance on a cycle with out_valid&out_ready at the rising edge. Otherwise hold.
- out_data and out_last must stay stable while out_valid=1 and out_ready=0.
- out_last=1 only in S3.
- On S3 handshake: pairs_sent+=1 (mod 2^16). Go to IDLE.
- Minimum latency: pops seen in IDLE cycle T -> out_valid first high in cycle T+3.
- Maximum throughput with out_ready=1 is one frame per 7 cycles; there is no back-to-back bypass.
- drain_en: gates only the IDLE->FETCH transition. Deasserting it mid-frame lets the frame complete.
- clr_stats=1: at the edge, pairs_sent<=0 and err_seen<=0.
  - clr_stats wins over a simultaneous increment or set.
  - It does not affect the FSM.
- busy=1 in FETCH..S3, 0 in IDLE.
- out_valid=0 in IDLE, FETCH and LATCH.
- rd_en_* is never asserted outside FETCH, so a FIFO is never popped when its population is 0.

Test Plan:
- Single pair: result=0x12345678, status=0, out_ready=1.
  - Required: out_data sequence 0x1234, 0x5678, 0x0000, 0x0000.
  - out_last on the 4th half-word; pairs_sent=1; err_seen=0.
  - Each rd_en pulses exactly 1 cycle; first out_valid at T+3.
- Backpressure: out_ready=0 for 5 cycles in S1.
  - Required: out_data held at 0x5678 with out_valid=1 throughout; no extra pops.
  - Frame completes after out_ready returns to 1.
- Error status: status=0x00000003.
  - Required: err_seen=1 after LATCH and stays 1 across the next pair with status=0.
  - clr_stats pulse -> err_seen=0, pairs_sent=0.
- Unbalanced FIFOs: result_pop=2, status_pop=0 for 20 cycles.
  - Required: no rd_en, busy=0.
  - Then status_pop=2 -> two frames emitted; pairs_sent=2.
- Reset mid-frame: rst=0 while in S2.
  - Required: all outputs 0 immediately (async); after release, state IDLE.
  - Next frame starts from S0 with new data.
- Wrap/gating: preload pairs_sent to 0xFFFF (via 65535 frames or force) -> next frame gives 0x0000.
  - With drain_en=0 in IDLE and both FIFOs non-empty: no pops.
